uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl - UART receive controller with 8N1 / 9-bit frame support.
//
// Ports
//   sys_clk         single clock, rising edge
//   sys_rst         synchronous active-high reset
//   uart_en         receiver enable (0 forces idle, keeps buffer and flags)
//   uart_baud       bit period minus one, in sys_clk cycles (minimum 3)
//   uart_prty_en    1 = 9-bit frames (8 data + bit9), 0 = 8N1
//   uart_rxie       receive interrupt enable
//   uart_rx         asynchronous serial input, idle high
//   uart_rxpnd_clr  pulse: clears pending, overrun and framing flags
//   uart_rxbuf_rd   pulse: buffer read, clears pending only
//   uart_rxbuf      received word {7'd0, bit9, data[7:0]}
//   uart_rxpnd      new word available
//   uart_rx_ovf     sticky overrun flag
//   uart_rx_ferr    sticky framing-error flag
//   uart_rx_int     uart_rxpnd & uart_rxie
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronized line
// START | timing to mid start bit; a high sample there is a false start
// DATA  | sampling 8 data bits, LSB first
// BIT9  | sampling the 9th bit (9-bit mode only)
// STOP  | sampling the stop bit, then delivering the word

module uart_rx_ctrl (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_en,
  input  logic [15:0] uart_baud,
  input  logic        uart_prty_en,
  input  logic        uart_rxie,
  input  logic        uart_rx,
  input  logic        uart_rxpnd_clr,
  input  logic        uart_rxbuf_rd,
  output logic [15:0] uart_rxbuf,
  output logic        uart_rxpnd,
  output logic        uart_rx_ovf,
  output logic        uart_rx_ferr,
  output logic        uart_rx_int
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    BIT9  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        rx_m, rx_s, rx_d;
  logic [15:0] baud_eff;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        bit9, bit9_nxt;
  logic        start_edge;
  logic        sample;
  logic        deliver;
  logic        pnd_cleared;

  assign baud_eff   = (uart_baud < 16'd3) ? 16'd3 : uart_baud;
  assign start_edge = rx_d & ~rx_s;
  assign sample     = (cnt == 16'd0);

  // Synchronizer and edge-detect flop idle high so reset never looks like a start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      bit9    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      bit9    <= bit9_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = sample ? baud_eff : cnt - 16'd1;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    bit9_nxt    = bit9;
    deliver     = 1'b0;
    if (!uart_en) begin
      state_nxt   = IDLE;
      cnt_nxt     = 16'd0;
      bit_idx_nxt = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = 16'd0;
          if (start_edge) begin
            state_nxt = START;
            cnt_nxt   = baud_eff >> 1;
          end
        end
        START: begin
          if (sample) begin
            if (rx_s) begin
              state_nxt = IDLE;
              cnt_nxt   = 16'd0;
            end else begin
              state_nxt   = DATA;
              bit_idx_nxt = 3'd0;
              bit9_nxt    = 1'b0;  // stays 0 for 8N1 frames
            end
          end
        end
        DATA: begin
          if (sample) begin
            shreg_nxt   = {rx_s, shreg[7:1]};
            bit_idx_nxt = bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state_nxt = uart_prty_en ? BIT9 : STOP;
          end
        end
        BIT9: begin
          if (sample) begin
            bit9_nxt  = rx_s;
            state_nxt = STOP;
          end
        end
        STOP: begin
          if (sample) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = 16'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
        end
      endcase
    end
  end

  // Clears are applied before the delivery sets, so a read in the delivery
  // cycle makes room for the new word instead of flagging an overrun.
  assign pnd_cleared = uart_rxpnd & ~(uart_rxpnd_clr | uart_rxbuf_rd);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      uart_rxbuf   <= 16'd0;
      uart_rxpnd   <= 1'b0;
      uart_rx_ovf  <= 1'b0;
      uart_rx_ferr <= 1'b0;
    end else begin
      uart_rxpnd   <= pnd_cleared | deliver;
      uart_rx_ovf  <= (uart_rx_ovf & ~uart_rxpnd_clr) | (deliver & pnd_cleared);
      uart_rx_ferr <= (uart_rx_ferr & ~uart_rxpnd_clr) | (deliver & ~rx_s);
      if (deliver && !pnd_cleared)
        uart_rxbuf <= {7'd0, bit9, shreg};
    end
  end

  assign uart_rx_int = uart_rxpnd & uart_rxie;

endmodule
